// File: rtl/axi_arbiter.sv
// axi_arbiter: single-outstanding AXI3 bridge that shares the core's AXI port
// between I-cache refill, D-cache refill and D-cache writeback, one whole-line
// burst at a time.
// Optional macro AXI_ARB_RR_EN: the two read requesters alternate when both
// are pending in IDLE (the writeback keeps top priority).
module axi_arbiter #(
    parameter int unsigned LINE_WORDS = 8
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic                      icache_rd_req,
    input  logic [31:0]               icache_rd_addr,
    output logic                      icache_rd_done,
    output logic [32*LINE_WORDS-1:0]  icache_rd_data,

    input  logic                      dcache_rd_req,
    input  logic [31:0]               dcache_rd_addr,
    output logic                      dcache_rd_done,
    output logic [32*LINE_WORDS-1:0]  dcache_rd_data,

    input  logic                      dcache_wr_req,
    input  logic [31:0]               dcache_wr_addr,
    input  logic [32*LINE_WORDS-1:0]  dcache_wr_data,
    output logic                      dcache_wr_done,

    output logic                      stallreq_from_axi,

    output logic [3:0]                arid,
    output logic [31:0]               araddr,
    output logic [3:0]                arlen,
    output logic [2:0]                arsize,
    output logic [1:0]                arburst,
    output logic                      arvalid,
    input  logic                      arready,

    input  logic [3:0]                rid,
    input  logic [31:0]               rdata,
    input  logic [1:0]                rresp,
    input  logic                      rlast,
    input  logic                      rvalid,
    output logic                      rready,

    output logic [3:0]                awid,
    output logic [31:0]               awaddr,
    output logic [3:0]                awlen,
    output logic [2:0]                awsize,
    output logic [1:0]                awburst,
    output logic                      awvalid,
    input  logic                      awready,

    output logic [3:0]                wid,
    output logic [31:0]               wdata,
    output logic [3:0]                wstrb,
    output logic                      wlast,
    output logic                      wvalid,
    input  logic                      wready,

    input  logic [3:0]                bid,
    input  logic [1:0]                bresp,
    input  logic                      bvalid,
    output logic                      bready
);

    localparam int unsigned LINE_W = 32 * LINE_WORDS;
    localparam int unsigned CNT_W  = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_WORDS - 1);

    typedef enum logic [2:0] {IDLE, AR, R, AW, W, B, DONE} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_ICACHE, OWN_DCACHE_RD, OWN_DCACHE_WR} owner_t;

    state_t           state;
    owner_t           owner;
    logic [CNT_W-1:0] beat_cnt;
    logic             pick_dcache_rd_c;

    // Word idx of a cache line, word 0 in the low bits.
    function automatic logic [31:0] line_word(input logic [LINE_W-1:0] line,
                                              input int unsigned idx);
        return line[32*idx +: 32];
    endfunction

    // Burst shape is fixed: whole line, 32-bit beats, incrementing.
    assign arlen   = 4'(LINE_WORDS - 1);
    assign awlen   = 4'(LINE_WORDS - 1);
    assign arsize  = 3'b010;
    assign awsize  = 3'b010;
    assign arburst = 2'b01;
    assign awburst = 2'b01;
    assign wstrb   = 4'hf;

    // Response ids and status are not used by this bridge.
    logic unused_axi_fields;
    assign unused_axi_fields = ^{rid, rresp, bid, bresp};

    // Pipeline must hold while a burst is in flight or any requester waits.
    assign stallreq_from_axi = (state != IDLE) | icache_rd_req | dcache_rd_req | dcache_wr_req;

`ifdef AXI_ARB_RR_EN
    logic last_rd_dcache;
    // With both reads pending, the requester that did not win last time goes.
    assign pick_dcache_rd_c = dcache_rd_req && (!icache_rd_req || !last_rd_dcache);
`else
    // D-cache refill always beats I-cache refill.
    assign pick_dcache_rd_c = dcache_rd_req;
`endif

    // Transaction FSM: grant, run one burst, pulse the owner's done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            owner          <= OWN_NONE;
            beat_cnt       <= '0;
            arid           <= '0;
            araddr         <= '0;
            arvalid        <= 1'b0;
            rready         <= 1'b0;
            awid           <= '0;
            awaddr         <= '0;
            awvalid        <= 1'b0;
            wid            <= '0;
            wdata          <= '0;
            wlast          <= 1'b0;
            wvalid         <= 1'b0;
            bready         <= 1'b0;
            icache_rd_done <= 1'b0;
            dcache_rd_done <= 1'b0;
            dcache_wr_done <= 1'b0;
            icache_rd_data <= '0;
            dcache_rd_data <= '0;
`ifdef AXI_ARB_RR_EN
            last_rd_dcache <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (dcache_wr_req) begin
                        owner   <= OWN_DCACHE_WR;
                        awaddr  <= dcache_wr_addr;
                        awid    <= 4'd1;
                        awvalid <= 1'b1;
                        state   <= AW;
                    end else if (pick_dcache_rd_c) begin
                        owner   <= OWN_DCACHE_RD;
                        araddr  <= dcache_rd_addr;
                        arid    <= 4'd1;
                        arvalid <= 1'b1;
                        state   <= AR;
`ifdef AXI_ARB_RR_EN
                        last_rd_dcache <= 1'b1;
`endif
                    end else if (icache_rd_req) begin
                        owner   <= OWN_ICACHE;
                        araddr  <= icache_rd_addr;
                        arid    <= 4'd0;
                        arvalid <= 1'b1;
                        state   <= AR;
`ifdef AXI_ARB_RR_EN
                        last_rd_dcache <= 1'b0;
`endif
                    end
                end
                AR: begin
                    if (arready) begin
                        arvalid  <= 1'b0;
                        rready   <= 1'b1;
                        beat_cnt <= '0;
                        state    <= R;
                    end
                end
                R: begin
                    if (rvalid) begin
                        if (owner == OWN_ICACHE) begin
                            icache_rd_data[32*int'(beat_cnt) +: 32] <= rdata;
                        end else begin
                            dcache_rd_data[32*int'(beat_cnt) +: 32] <= rdata;
                        end
                        if (beat_cnt != LAST_BEAT) begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                        if (rlast) begin
                            rready <= 1'b0;
                            state  <= DONE;
                            if (owner == OWN_ICACHE) begin
                                icache_rd_done <= 1'b1;
                            end else begin
                                dcache_rd_done <= 1'b1;
                            end
                        end
                    end
                end
                AW: begin
                    if (awready) begin
                        awvalid  <= 1'b0;
                        wvalid   <= 1'b1;
                        wid      <= 4'd1;
                        beat_cnt <= '0;
                        wdata    <= line_word(dcache_wr_data, 32'd0);
                        wlast    <= 1'b0;
                        state    <= W;
                    end
                end
                W: begin
                    if (wready) begin
                        if (beat_cnt == LAST_BEAT) begin
                            wvalid <= 1'b0;
                            wlast  <= 1'b0;
                            bready <= 1'b1;
                            state  <= B;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                            wdata    <= line_word(dcache_wr_data, 32'(beat_cnt) + 32'd1);
                            wlast    <= ((beat_cnt + 1'b1) == LAST_BEAT);
                        end
                    end
                end
                B: begin
                    if (bvalid) begin
                        bready         <= 1'b0;
                        dcache_wr_done <= 1'b1;
                        state          <= DONE;
                    end
                end
                DONE: begin
                    icache_rd_done <= 1'b0;
                    dcache_rd_done <= 1'b0;
                    dcache_wr_done <= 1'b0;
                    owner          <= OWN_NONE;
                    state          <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_arbiter.sv
// tb_axi_arbiter: randomized scoreboard bench for axi_arbiter with a reactive
// AXI slave, a requester driver and a done-pulse monitor.
`timescale 1ns/1ps
module tb_axi_arbiter;
    localparam int unsigned LW     = 8;
    localparam int unsigned LINE_W = 32 * LW;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic              icache_rd_req = 1'b0;
    logic [31:0]       icache_rd_addr = '0;
    logic              icache_rd_done;
    logic [LINE_W-1:0] icache_rd_data;
    logic              dcache_rd_req = 1'b0;
    logic [31:0]       dcache_rd_addr = '0;
    logic              dcache_rd_done;
    logic [LINE_W-1:0] dcache_rd_data;
    logic              dcache_wr_req = 1'b0;
    logic [31:0]       dcache_wr_addr = '0;
    logic [LINE_W-1:0] dcache_wr_data = '0;
    logic              dcache_wr_done;
    logic              stallreq_from_axi;

    logic [3:0]  arid;   logic [31:0] araddr; logic [3:0] arlen; logic [2:0] arsize;
    logic [1:0]  arburst; logic arvalid; logic arready;
    logic [3:0]  rid;    logic [31:0] rdata;  logic [1:0] rresp; logic rlast; logic rvalid; logic rready;
    logic [3:0]  awid;   logic [31:0] awaddr; logic [3:0] awlen; logic [2:0] awsize;
    logic [1:0]  awburst; logic awvalid; logic awready;
    logic [3:0]  wid;    logic [31:0] wdata;  logic [3:0] wstrb; logic wlast; logic wvalid; logic wready;
    logic [3:0]  bid;    logic [1:0]  bresp;  logic bvalid; logic bready;

    axi_arbiter #(.LINE_WORDS(LW)) dut (
        .clk(clk), .rst(rst),
        .icache_rd_req(icache_rd_req), .icache_rd_addr(icache_rd_addr),
        .icache_rd_done(icache_rd_done), .icache_rd_data(icache_rd_data),
        .dcache_rd_req(dcache_rd_req), .dcache_rd_addr(dcache_rd_addr),
        .dcache_rd_done(dcache_rd_done), .dcache_rd_data(dcache_rd_data),
        .dcache_wr_req(dcache_wr_req), .dcache_wr_addr(dcache_wr_addr),
        .dcache_wr_data(dcache_wr_data), .dcache_wr_done(dcache_wr_done),
        .stallreq_from_axi(stallreq_from_axi),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected completion: kind 0 = I-read, 1 = D-read, 2 = D-write.
    typedef struct {
        int                kind;
        logic [31:0]       addr;
        logic [LINE_W-1:0] line;
    } exp_t;
    exp_t exp_q[$];

    int checks   = 0;
    int failures = 0;

    // Slave configuration and observations
    bit                stall_en    = 1'b0;
    bit                data_tagged = 1'b0;
    int                ar_stall    = 0;
    int                w_stall_q[$];
    logic [31:0]       ar_addr_log = '0;
    logic [3:0]        ar_id_log   = '0;
    logic [31:0]       aw_addr_log = '0;
    logic [3:0]        aw_id_log   = '0;
    logic [LINE_W-1:0] w_line      = '0;
    int                w_cnt       = 0;
    int                b_cyc       = 0;
    bit                b_pending   = 1'b0;
    int                b_delay     = 0;
    bit                r_active    = 1'b0;
    int                r_beat      = 0;
    logic [31:0]       r_addr      = '0;

    // Reference-model state
    int model_last_rd  = 0;   // 0 = I-cache served last, 1 = D-cache
    int last_raise_cyc = 0;
    int i_done_cyc     = 0;

    task automatic chk(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Data the slave returns for beat i of a read of line a.
    function automatic logic [31:0] rword(input logic [31:0] a, input int i);
        if (data_tagged) return a ^ (32'(i) << 24) ^ 32'h5a5a_0000;
        return 32'h100 + 32'(i);
    endfunction

    function automatic logic [LINE_W-1:0] rline(input logic [31:0] a);
        logic [LINE_W-1:0] l;
        for (int k = 0; k < LW; k++) l[32*k +: 32] = rword(a, k);
        return l;
    endfunction

    // Reactive AXI slave, driven on the falling edge.
    initial begin
        bit stall_now;
        arready = 0; rvalid = 0; rdata = 0; rlast = 0; rid = 0; rresp = 0;
        awready = 0; wready = 0; bvalid = 0; bid = 0; bresp = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                arready = 0; rvalid = 0; rlast = 0; awready = 0; wready = 0; bvalid = 0;
                r_active = 0; b_pending = 0; w_cnt = 0;
                continue;
            end
            // R
            rvalid = 0; rlast = 0;
            if (r_active && rready && (!stall_en || $urandom_range(3) != 0)) begin
                rvalid = 1;
                rdata  = rword(r_addr, r_beat);
                rlast  = (r_beat == LW - 1);
                rid    = 4'($urandom);
                rresp  = 2'($urandom);
                r_beat++;
                if (r_beat == LW) r_active = 0;
            end
            // AR
            arready = 0;
            if (arvalid) begin
                if (ar_stall > 0) ar_stall--;
                else if (!stall_en || $urandom_range(3) != 0) begin
                    arready     = 1;
                    ar_addr_log = araddr;
                    ar_id_log   = arid;
                    chk("arlen", arlen, LW - 1);
                    chk("arsize", arsize, 3'b010);
                    chk("arburst", arburst, 2'b01);
                    r_active = 1; r_beat = 0; r_addr = araddr;
                end
            end
            // B
            bvalid = 0;
            if (b_pending && bready) begin
                if (b_delay > 0) b_delay--;
                else begin
                    bvalid = 1; bid = 4'($urandom); bresp = 2'($urandom);
                    b_pending = 0; b_cyc = cyc;
                end
            end
            // W
            wready = 0;
            if (wvalid) begin
                stall_now = 0;
                for (int k = 0; k < w_stall_q.size(); k++) begin
                    if (w_stall_q[k] == w_cnt) begin
                        w_stall_q.delete(k);
                        stall_now = 1;
                        break;
                    end
                end
                if (stall_en && $urandom_range(3) == 0) stall_now = 1;
                if (!stall_now) begin
                    wready = 1;
                    chk("wid", wid, 1);
                    chk("wstrb", wstrb, 4'hf);
                    chk("wlast", wlast, (w_cnt == LW - 1));
                    if (w_cnt < LW) w_line[32*w_cnt +: 32] = wdata;
                    w_cnt++;
                    if (w_cnt == LW) begin
                        b_pending = 1;
                        b_delay   = stall_en ? int'($urandom_range(3)) : 0;
                    end
                end
            end
            // AW
            awready = 0;
            if (awvalid && (!stall_en || $urandom_range(3) != 0)) begin
                awready     = 1;
                aw_addr_log = awaddr;
                aw_id_log   = awid;
                chk("awlen", awlen, LW - 1);
                chk("awburst", awburst, 2'b01);
                w_cnt  = 0;
                w_line = '0;
            end
        end
    end

    // Monitor: pop the scoreboard on every done pulse and compare.
    initial begin
        exp_t e;
        bit   pi, pd, pw;
        int   ndone;
        pi = 0; pd = 0; pw = 0;
        forever begin
            @(negedge clk);
            ndone = int'(icache_rd_done) + int'(dcache_rd_done) + int'(dcache_wr_done);
            if (ndone != 0) begin
                chk("done_onehot", (ndone > 1), 0);
                if (icache_rd_done) chk("i_done_width", pi, 0);
                if (dcache_rd_done) chk("d_done_width", pd, 0);
                if (dcache_wr_done) chk("w_done_width", pw, 0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    if (icache_rd_done) begin
                        chk("owner_i", 0, e.kind);
                        chk("i_araddr", ar_addr_log, e.addr);
                        chk("i_arid", ar_id_log, 0);
                        chk("i_line", icache_rd_data, e.line);
                        i_done_cyc = cyc;
                    end else if (dcache_rd_done) begin
                        chk("owner_d", 1, e.kind);
                        chk("d_araddr", ar_addr_log, e.addr);
                        chk("d_arid", ar_id_log, 1);
                        chk("d_line", dcache_rd_data, e.line);
                    end else begin
                        chk("owner_w", 2, e.kind);
                        chk("w_awaddr", aw_addr_log, e.addr);
                        chk("w_awid", aw_id_log, 1);
                        chk("w_beats", w_cnt, LW);
                        chk("w_line", w_line, e.line);
                        chk("w_done_after_b", cyc - b_cyc, 1);
                    end
                end
            end
            pi = icache_rd_done; pd = dcache_rd_done; pw = dcache_wr_done;
        end
    end

    // Service order from the arbitration rules: writeback first, then reads.
    task automatic model_push(input bit w, input bit d, input bit i,
                              input logic [31:0] wa, input logic [31:0] da,
                              input logic [31:0] ia, input logic [LINE_W-1:0] wl);
        exp_t e;
        bit   d_first;
        if (w) begin e.kind = 2; e.addr = wa; e.line = wl; exp_q.push_back(e); end
`ifdef AXI_ARB_RR_EN
        d_first = (model_last_rd == 0);
`else
        d_first = 1'b1;
`endif
        if (d && i) begin
            if (d_first) begin
                e.kind = 1; e.addr = da; e.line = rline(da); exp_q.push_back(e);
                e.kind = 0; e.addr = ia; e.line = rline(ia); exp_q.push_back(e);
                model_last_rd = 0;
            end else begin
                e.kind = 0; e.addr = ia; e.line = rline(ia); exp_q.push_back(e);
                e.kind = 1; e.addr = da; e.line = rline(da); exp_q.push_back(e);
                model_last_rd = 1;
            end
        end else if (d) begin
            e.kind = 1; e.addr = da; e.line = rline(da); exp_q.push_back(e);
            model_last_rd = 1;
        end else if (i) begin
            e.kind = 0; e.addr = ia; e.line = rline(ia); exp_q.push_back(e);
            model_last_rd = 0;
        end
    endtask

    // Raise a set of requests together from IDLE and hold each until its done.
    task automatic run_round(input bit w, input bit d, input bit i,
                             input logic [31:0] wa, input logic [31:0] da,
                             input logic [31:0] ia, input logic [LINE_W-1:0] wl,
                             input bit chk_stall, input int hold_chk);
        int pend;
        int budget;
        model_push(w, d, i, wa, da, ia, wl);
        @(negedge clk);
        dcache_wr_addr = wa; dcache_wr_data = wl; dcache_wr_req = w;
        dcache_rd_addr = da; dcache_rd_req = d;
        icache_rd_addr = ia; icache_rd_req = i;
        last_raise_cyc = cyc;
        pend   = int'(w) + int'(d) + int'(i);
        budget = 0;
        while (pend > 0 && budget < 600) begin
            @(negedge clk);
            budget++;
            if (chk_stall) chk("stall_busy", stallreq_from_axi, 1);
            if (budget <= hold_chk) begin
                chk("ar_hold_valid", arvalid, 1);
                chk("ar_hold_addr", araddr, da);
                chk("ar_hold_rready", rready, 0);
            end
            if (icache_rd_done && icache_rd_req) begin icache_rd_req = 0; pend--; end
            if (dcache_rd_done && dcache_rd_req) begin dcache_rd_req = 0; pend--; end
            if (dcache_wr_done && dcache_wr_req) begin dcache_wr_req = 0; pend--; end
        end
        if (pend > 0) begin
            chk("round_timeout", pend, 0);
            icache_rd_req = 0; dcache_rd_req = 0; dcache_wr_req = 0;
        end
        @(negedge clk);
        if (chk_stall) chk("stall_idle", stallreq_from_axi, 0);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_arvalid"}, arvalid, 0);
        chk({tag, "_rready"}, rready, 0);
        chk({tag, "_awvalid"}, awvalid, 0);
        chk({tag, "_wvalid"}, wvalid, 0);
        chk({tag, "_bready"}, bready, 0);
        chk({tag, "_dones"}, {icache_rd_done, dcache_rd_done, dcache_wr_done}, 0);
        chk({tag, "_stall"}, stallreq_from_axi, 0);
        chk({tag, "_icache_data"}, icache_rd_data, 0);
    endtask

    initial begin
        logic [LINE_W-1:0] wl;
        int                sel;
        int                found;

        // Reset state
        rst = 1;
        repeat (3) @(posedge clk);
        #1;
        chk_idle_outputs("reset");
        chk("reset_araddr", araddr, 0);
        chk("reset_dcache_data", dcache_rd_data, 0);
        chk("reset_awid", awid, 0);
        chk("reset_wdata", wdata, 0);
        chk("reset_arlen", arlen, LW - 1);
        chk("reset_awsize", awsize, 3'b010);
        chk("reset_wstrb", wstrb, 4'hf);
        @(negedge clk);
        rst = 0;
        model_last_rd = 0;

        // Lone I-cache read, zero-wait slave, 0x100+beat data
        data_tagged = 0;
        run_round(0, 0, 1, 32'h0, 32'h0, 32'h1fc0_0020, '0, 0, 0);
        chk("i_done_cycle", i_done_cyc - last_raise_cyc, LW + 2);

        // Writeback with wready low on beats 3 and 5
        data_tagged = 1;
        for (int k = 0; k < LW; k++) wl[32*k +: 32] = 32'hA0 + 32'(k);
        w_stall_q = '{3, 5};
        run_round(1, 0, 0, 32'h0000_1000, 32'h0, 32'h0, wl, 0, 0);
        chk("w_stalls_used", w_stall_q.size(), 0);

        // All three at once; stall held until the third done
        run_round(1, 1, 1, 32'h0000_2040, 32'h0000_3080, 32'h1fc0_1000, ~wl, 1, 0);

        // Same-cycle I-read and D-read, four times, then D alone followed by both
        for (int r = 0; r < 4; r++)
            run_round(0, 1, 1, 32'h0, 32'h0001_0000 + 32'(r) * 32'h20,
                      32'h0002_0000 + 32'(r) * 32'h20, '0, 0, 0);
        run_round(0, 1, 0, 32'h0, 32'h0003_0000, 32'h0, '0, 0, 0);
        run_round(0, 1, 1, 32'h0, 32'h0003_0020, 32'h0004_0000, '0, 0, 0);

        // Reset on the 4th R beat of an I-read
        icache_rd_addr = 32'h0000_4000;
        icache_rd_req  = 1;
        found = 0;
        for (int t = 0; t < 60 && found == 0; t++) begin
            @(negedge clk);
            #1;
            if (r_active && r_beat == 4) found = 1;
        end
        chk("reset_beat_reached", found, 1);
        rst = 1;
        icache_rd_req = 0;
        @(posedge clk);
        #1;
        chk_idle_outputs("midburst_rst");
        @(negedge clk);
        #1;
        rst = 0;
        model_last_rd = 0;
        run_round(0, 0, 1, 32'h0, 32'h0, 32'h0000_5000, '0, 0, 0);

        // arready held low for five cycles
        ar_stall = 5;
        run_round(0, 1, 0, 32'h0, 32'h0000_6020, 32'h0, '0, 0, 5);

        // Randomized rounds with a stalling slave
        stall_en = 1;
        for (int r = 0; r < 25; r++) begin
            sel = int'($urandom_range(1, 7));
            for (int k = 0; k < LW; k++) wl[32*k +: 32] = $urandom;
            run_round(sel[2], sel[1], sel[0],
                      $urandom & 32'hffff_ffe0, $urandom & 32'hffff_ffe0,
                      $urandom & 32'hffff_ffe0, wl, 1, 0);
        end

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global run-time bound
    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
